// File: rtl/shreg_seq_if.sv
// Command/status bundle for shreg_seq. The abort/aborted pair exists only when
// SHREG_ABORT_EN is defined.
interface shreg_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) ();
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] data_in;
  logic             ser_in_msb;
  logic             ser_in_lsb;
  logic [WIDTH-1:0] data_out;
  logic             carry_out;
  logic             busy;
  logic             done;
`ifdef SHREG_ABORT_EN
  logic             abort;
  logic             aborted;

  modport master (
    output start, op, amt, data_in, ser_in_msb, ser_in_lsb, abort,
    input  data_out, carry_out, busy, done, aborted
  );
  modport slave (
    input  start, op, amt, data_in, ser_in_msb, ser_in_lsb, abort,
    output data_out, carry_out, busy, done, aborted
  );
`else
  modport master (
    output start, op, amt, data_in, ser_in_msb, ser_in_lsb,
    input  data_out, carry_out, busy, done
  );
  modport slave (
    input  start, op, amt, data_in, ser_in_msb, ser_in_lsb,
    output data_out, carry_out, busy, done
  );
`endif
endinterface

// File: rtl/shreg_seq.sv
// Universal shift register with a bit-serial sequencer: one shift position per clock.
// Define SHREG_ABORT_EN to add abort/aborted for cancelling a running command.
module shreg_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input logic        clk,
  input logic        clr,
  shreg_seq_if.slave bus
);

  localparam logic [2:0] OpLoad = 3'b000;
  localparam logic [2:0] OpShl  = 3'b001;
  localparam logic [2:0] OpShr  = 3'b010;
  localparam logic [2:0] OpSra  = 3'b011;
  localparam logic [2:0] OpRol  = 3'b100;
  localparam logic [2:0] OpRor  = 3'b101;
  localparam logic [2:0] OpShls = 3'b110;
  localparam logic [2:0] OpShrs = 3'b111;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [AMT_W-1:0] AmtOne = AMT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;
  logic             abort_req;

`ifdef SHREG_ABORT_EN
  logic aborted_q, aborted_d;

  assign abort_req = bus.abort;
  assign aborted_d = (state_q == StRun) && bus.abort;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= aborted_d;
    end
  end

  assign bus.aborted = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  // The first step happens on the accept edge, so in IDLE the live op drives the shifter.
  always_comb begin
    step_op    = (state_q == StRun) ? op_q : bus.op;
    step_data  = data_q;
    step_carry = 1'b0;
    case (step_op)
      OpShl: begin
        step_carry = data_q[WIDTH-1];
        step_data  = {data_q[WIDTH-2:0], 1'b0};
      end
      OpShr: begin
        step_carry = data_q[0];
        step_data  = {1'b0, data_q[WIDTH-1:1]};
      end
      OpSra: begin
        step_carry = data_q[0];
        step_data  = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      end
      OpRol: begin
        step_carry = data_q[WIDTH-1];
        step_data  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      end
      OpRor: begin
        step_carry = data_q[0];
        step_data  = {data_q[0], data_q[WIDTH-1:1]};
      end
      OpShls: begin
        step_carry = data_q[WIDTH-1];
        step_data  = {data_q[WIDTH-2:0], bus.ser_in_lsb};
      end
      OpShrs: begin
        step_carry = data_q[0];
        step_data  = {bus.ser_in_msb, data_q[WIDTH-1:1]};
      end
      default: begin
        step_carry = 1'b0;
        step_data  = data_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    if (state_q == StIdle) begin
      if (bus.start) begin
        if (bus.op == OpLoad) begin
          data_d  = bus.data_in;
          carry_d = 1'b0;
          done_d  = 1'b1;
        end else if (bus.amt == '0) begin
          done_d = 1'b1;
        end else begin
          data_d  = step_data;
          carry_d = step_carry;
          if (bus.amt == AmtOne) begin
            done_d = 1'b1;
          end else begin
            state_d = StRun;
            op_d    = bus.op;
            cnt_d   = bus.amt - AmtOne;
          end
        end
      end
    end else if (abort_req) begin
      // Abort wins over the final step: registers keep their partial result.
      state_d = StIdle;
    end else begin
      data_d  = step_data;
      carry_d = step_carry;
      cnt_d   = cnt_q - AmtOne;
      if (cnt_q == AmtOne) begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      op_q    <= OpLoad;
      cnt_q   <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.carry_out = carry_q;
  assign bus.busy      = (state_q == StRun);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_shreg_seq.sv
// Bench for shreg_seq: directed table, hand-written corner sequences and random
// commands checked against an arithmetic model of the shift rules.
module tb_shreg_seq;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 4;

  localparam logic [2:0] LOAD = 3'd0;
  localparam logic [2:0] SHL  = 3'd1;
  localparam logic [2:0] SHR  = 3'd2;
  localparam logic [2:0] SRA  = 3'd3;
  localparam logic [2:0] ROL  = 3'd4;
  localparam logic [2:0] ROR  = 3'd5;
  localparam logic [2:0] SHLS = 3'd6;
  localparam logic [2:0] SHRS = 3'd7;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  shreg_seq_if #(.WIDTH(W), .AMT_W(AW)) bus ();
  shreg_seq #(.WIDTH(W), .AMT_W(AW)) dut (.clk(clk), .clr(clr), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;
  int mdl_data = 0;
  int mdl_carry = 0;

  typedef struct {
    logic [2:0] op;
    int         amt;
    int         data;
    int         sm;
    int         sl;
    int         exp_d;
    int         exp_c;
    bit         mid;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One shift position, computed with plain arithmetic on an 8-bit value.
  function automatic void mstep(input logic [2:0] o, input int sm, input int sl);
    int v;
    int c;
    v = mdl_data;
    c = 0;
    case (o)
      SHL:  begin c = v / 128; v = (v * 2) % 256;                 end
      SHR:  begin c = v % 2;   v = v / 2;                         end
      SRA:  begin c = v % 2;   v = v / 2 + ((v >= 128) ? 128 : 0); end
      ROL:  begin c = v / 128; v = (v * 2) % 256 + c;             end
      ROR:  begin c = v % 2;   v = v / 2 + c * 128;               end
      SHLS: begin c = v / 128; v = (v * 2) % 256 + sl;            end
      SHRS: begin c = v % 2;   v = v / 2 + sm * 128;              end
      default: begin c = mdl_carry; end
    endcase
    mdl_data  = v;
    mdl_carry = c;
  endfunction

  function automatic void mcmd(input logic [2:0] o, input int a, input int d,
                               input int sm, input int sl);
    if (o == LOAD) begin
      mdl_data  = d;
      mdl_carry = 0;
    end else begin
      for (int i = 0; i < a; i++) mstep(o, sm, sl);
    end
  endfunction

  // Issue one command, wait (bounded) for done, check result and busy length.
  // Returns at the negedge where done is high.
  task automatic cmd(input string tag, input logic [2:0] o, input int a, input int d,
                     input int sm, input int sl, input bit mid_load);
    int busy_cyc;
    int guard;
    int exp_busy;
    busy_cyc = 0;
    guard    = 0;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.op         = o;
    bus.amt        = a[AW-1:0];
    bus.data_in    = d[W-1:0];
    bus.ser_in_msb = sm[0];
    bus.ser_in_lsb = sl[0];
    mcmd(o, a, d, sm, sl);
    exp_busy = (o != LOAD && a > 1) ? a - 1 : 0;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && guard < 40) begin
      if (bus.busy === 1'b1) busy_cyc++;
      if (mid_load && guard == 0) begin
        bus.start   = 1'b1;
        bus.op      = LOAD;
        bus.data_in = 8'h00;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    bus.start = 1'b0;
    check({tag, " done seen"}, 32'(guard < 40), 32'd1);
    check({tag, " busy cycles"}, busy_cyc, exp_busy);
    check({tag, " busy at done"}, bus.busy, 1'b0);
    check({tag, " data"}, bus.data_out, mdl_data);
    check({tag, " carry"}, bus.carry_out, mdl_carry);
  endtask

  task automatic done_drop(input string tag);
    @(negedge clk);
    check({tag, " done drop"}, bus.done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start      = 1'b0;
    bus.op         = LOAD;
    bus.amt        = '0;
    bus.data_in    = '0;
    bus.ser_in_msb = 1'b0;
    bus.ser_in_lsb = 1'b0;
`ifdef SHREG_ABORT_EN
    bus.abort      = 1'b0;
`endif
    clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst data", bus.data_out, 8'h00);
    check("rst carry", bus.carry_out, 1'b0);
    check("rst busy", bus.busy, 1'b0);
    check("rst done", bus.done, 1'b0);
    clr = 1'b1;

    tbl.push_back('{LOAD, 0, 'hC3, 0, 0, 'hC3, 0, 1'b0});
    tbl.push_back('{SHL,  3, 0,    0, 0, 'h18, 0, 1'b1});
    tbl.push_back('{LOAD, 0, 'h84, 0, 0, 'h84, 0, 1'b0});
    tbl.push_back('{SRA,  2, 0,    0, 0, 'hE1, 0, 1'b0});
    tbl.push_back('{SHR,  0, 0,    0, 0, 'hE1, 0, 1'b0});
    tbl.push_back('{LOAD, 0, 'hA5, 0, 0, 'hA5, 0, 1'b0});
    tbl.push_back('{ROR,  4, 0,    0, 0, 'h5A, 0, 1'b0});
    tbl.push_back('{ROL,  8, 0,    0, 0, 'h5A, 0, 1'b0});
    tbl.push_back('{SRA,  9, 0,    0, 0, 'h00, 0, 1'b0});
    foreach (tbl[i]) begin
      cmd($sformatf("tbl%0d", i), tbl[i].op, tbl[i].amt, tbl[i].data,
          tbl[i].sm, tbl[i].sl, tbl[i].mid);
      check($sformatf("tbl%0d exp data", i), bus.data_out, tbl[i].exp_d);
      check($sformatf("tbl%0d exp carry", i), bus.carry_out, tbl[i].exp_c);
      done_drop($sformatf("tbl%0d", i));
    end

    // Back-to-back: new command accepted in the done cycle.
    cmd("b2b load", LOAD, 0, 'h00, 0, 0, 1'b0);
    cmd("b2b shrs", SHRS, 8, 0, 1, 0, 1'b0);
    check("b2b shrs ff", bus.data_out, 8'hFF);
    bus.start      = 1'b1;
    bus.op         = SHLS;
    bus.amt        = 4'd2;
    bus.ser_in_lsb = 1'b0;
    mcmd(SHLS, 2, 0, 0, 0);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b accepted busy", bus.busy, 1'b1);
    check("b2b mid done", bus.done, 1'b0);
    @(negedge clk);
    check("b2b done", bus.done, 1'b1);
    check("b2b data", bus.data_out, 8'hFC);
    check("b2b carry", bus.carry_out, 1'b1);
    check("b2b model", bus.data_out, mdl_data);
    done_drop("b2b");

    // Asynchronous reset in the middle of a long command.
    cmd("clr load", LOAD, 0, 'hFF, 0, 0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = SHL;
    bus.amt   = 4'd10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("clr partial data", bus.data_out, 8'hF0);
    clr = 1'b0;
    #1;
    check("clr data", bus.data_out, 8'h00);
    check("clr carry", bus.carry_out, 1'b0);
    check("clr busy", bus.busy, 1'b0);
    check("clr done", bus.done, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("clr no done", bus.done, 1'b0);
    end
    mdl_data  = 0;
    mdl_carry = 0;

`ifdef SHREG_ABORT_EN
    cmd("abt load", LOAD, 0, 'hFF, 0, 0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = SHL;
    bus.amt   = 4'd10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abt busy", bus.busy, 1'b0);
    check("abt done", bus.done, 1'b0);
    check("abt pulse", bus.aborted, 1'b1);
    check("abt data", bus.data_out, 8'hF0);
    check("abt carry", bus.carry_out, 1'b1);
    @(negedge clk);
    check("abt pulse drop", bus.aborted, 1'b0);
    check("abt no done", bus.done, 1'b0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abt idle ignored", bus.aborted, 1'b0);
    mdl_data  = 'hF0;
    mdl_carry = 1;
`endif

    for (int k = 0; k < 40; k++) begin
      logic [2:0] o;
      int a;
      int d;
      int sm;
      int sl;
      o  = 3'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 15));
      d  = int'($urandom_range(0, 255));
      sm = int'($urandom_range(0, 1));
      sl = int'($urandom_range(0, 1));
      cmd($sformatf("rnd%0d op%0d amt%0d", k, o, a), o, a, d, sm, sl, 1'b0);
      done_drop($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/shreg_seq.md
Name: shreg_seq

Overview:
- Parametrised universal shift register: WIDTH-bit register with parallel load and logical, arithmetic, rotate and serial-fill shifts.
- A single command can shift by a multi-bit amount. A sequencer applies one bit-position per clock, with start/busy/done handshake.
- Successor to the fixed 4-bit hold/shift/load register. Used by datapath blocks that need variable shifts without a barrel shifter.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AMT_W, 4, width of the shift-amount field; max amount 2^AMT_W-1.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous active-low reset
- start  input  1  command strobe; accepted only when busy=0
- op  input  3  operation code (encodings under Behaviour)
- amt  input  AMT_W  shift amount; ignored for LOAD
- data_in  input  WIDTH  parallel load value
- ser_in_msb  input  1  fill bit entering the MSB on SHRS
- ser_in_lsb  input  1  fill bit entering the LSB on SHLS
- data_out  output  WIDTH  register contents
- carry_out  output  1  bit shifted or rotated out by the most recent shift step
- busy  output  1  multi-cycle command in progress
- done  output  1  one-cycle pulse when a command completes

Behaviour:
- Op encodings:
  - 000 LOAD
  - 001 SHL: logical left, 0 in
  - 010 SHR: logical right, 0 in
  - 011 SRA: arithmetic right, MSB replicated
  - 100 ROL
  - 101 ROR
  - 110 SHLS: left, LSB = ser_in_lsb, sampled each step
  - 111 SHRS: right, MSB = ser_in_msb, sampled each step
- Reset (clr=0, async): data_out=0, carry_out=0, busy=0, done=0, counter=0, state IDLE. Takes effect immediately, including mid-command; the command is discarded with no done pulse.
- States: IDLE, RUN. busy=1 exactly when state=RUN.
- IDLE, start=1 on a clock edge (accept edge E0):
  - LOAD: data_out<=data_in, carry_out<=0, done<=1, stay IDLE.
  - Shift op, amt=0: data_out and carry_out unchanged, done<=1, stay IDLE.
  - Shift op, amt=1: one shift step at E0, done<=1, stay IDLE.
  - Shift op, amt=N>1: first step at E0; latch op; counter<=N-1; go RUN.
- RUN, each edge:
  - One step using the latched op; counter decrements.
  - On the step where counter=1: done<=1, go IDLE.
  - Total steps = N, at edges E0..E(N-1). done is high for the cycle after E(N-1); busy is high from after E0 until after E(N-1).
- start while busy=1 is ignored, and op/amt changes have no effect. start is accepted in the cycle where done=1, since busy=0 then: back-to-back commands.
- done is a registered single-cycle pulse. It deasserts on the next edge unless a new command completes on that edge.
- carry_out per step: the MSB before the step for left ops, the LSB before the step for right ops. Holds its value between commands.
- amt >= WIDTH is legal: steps continue, so SHL/SHR give all-zero, SRA gives all-sign, rotates wrap modulo WIDTH.
- No combinational path from inputs to outputs; all outputs registered.

Optional Feature:
- Macro SHREG_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit, registered pulse, reset 0).
  - abort=1 in RUN: no shift step on that edge, go IDLE, busy<=0, done stays 0, aborted<=1 for one cycle; data_out and carry_out keep their partial values.
  - abort in IDLE is ignored. Abort takes priority over the final step.
- Undefined: no abort/aborted ports; commands always run to completion or reset.

Test Plan (WIDTH=8, AMT_W=4):
- clr=0 for 2 cycles then release; LOAD data_in=0xC3 -> after next edge data_out=0xC3, carry_out=0, done high 1 cycle, busy never high.
- From 0xC3, SHL amt=3 -> busy high 2 cycles, done high after the 3rd edge, data_out=0x18, carry_out=0. A start with op=LOAD pulsed mid-run is ignored.
- LOAD 0x84, then SRA amt=2 -> data_out=0xE1, carry_out=0. Then SHR amt=0 -> done next cycle, data_out still 0xE1.
- LOAD 0xA5, ROR amt=4 -> data_out=0x5A, carry_out=0. Then ROL amt=8 -> data_out=0x5A, 8 steps.
- LOAD 0x00, SHRS amt=8 with ser_in_msb=1 -> 0xFF after 8 steps. Reassert start in the done cycle with SHLS amt=2, ser_in_lsb=0 -> 0xFC.
- SHL amt=10 started from 0xFF, clr pulsed low after 4 steps -> outputs 0 immediately, no done pulse. With SHREG_ABORT_EN, the same run with abort after 4 steps -> data_out=0xF0, aborted pulse, done stays 0.
